max_seq_driver: RTL and testbench

Stimulus and sequencing block for the max-finder control FSM and its datapath. It buffers up to DEPTH unsigned samples and streams one per cycle while holding `start` high. It then drops `start`, waits for `done`, and captures the datapath's max register. It also tracks the expected maximum itself and flags any disagreement with the captured value.

---
 rtl/max_seq_driver.sv | 173 +++++++++++++++++
 tb/tb_max_seq_driver.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/max_seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : max_seq_driver
// Description : Stimulus/sequencing driver for a max-finder FSM + datapath.
//               Buffers up to DEPTH unsigned samples, streams them one per
//               cycle with start held high, waits for done, captures the
//               datapath max register and compares it against an internally
//               tracked maximum.
// Ports       : clk, rst (async, active-low)
//               wr_en/wr_data   - sample buffer write
//               go              - launch a run over the buffered samples
//               busy, count     - run-in-progress flag, samples buffered
//               start, data_out - stream towards the FSM / datapath
//               done_in, max_in - completion and max value from the datapath
//               result, result_valid, mismatch, timeout - run report
//               wr_err          - sticky dropped-write flag
// Revision    : 1.0 - initial release
// ============================================================================
module max_seq_driver #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     go,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     start,
    output logic [DATA_W-1:0]        data_out,
    input  logic                     done_in,
    input  logic [DATA_W-1:0]        max_in,
    output logic [DATA_W-1:0]        result,
    output logic                     result_valid,
    output logic                     mismatch,
    output logic                     timeout,
    output logic                     wr_err
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_buf [DEPTH];
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_CW-1:0]     r_sent;     // samples presented so far in this run
    logic [c_TW-1:0]     r_wait;     // DRAIN cycles elapsed
    logic [DATA_W-1:0]   r_exp_max;

    logic                w_full;
    logic                w_go_ok;
    logic                w_wr_ok;
    logic                w_wr_drop;
    logic [DATA_W-1:0]   w_rd_data;

    assign w_full    = (count == c_CW'(DEPTH));
    assign w_go_ok   = (r_state == ST_IDLE) && go && (count != '0);
    // An accepted go takes priority over a same-cycle write.
    assign w_wr_ok   = (r_state == ST_IDLE) && wr_en && !w_full && !w_go_ok;
    assign w_wr_drop = wr_en && !w_wr_ok;
    assign w_rd_data = r_buf[r_rd_ptr];

    // Sample storage carries no reset: stale contents are unreachable once
    // count and the pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_buf[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_sent       <= '0;
            r_wait       <= '0;
            r_exp_max    <= '0;
            busy         <= 1'b0;
            count        <= '0;
            start        <= 1'b0;
            data_out     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            mismatch     <= 1'b0;
            timeout      <= 1'b0;
            wr_err       <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (w_wr_drop) begin
                wr_err <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_go_ok) begin
                        // rd_ptr is 0 here, so w_rd_data is the first sample.
                        r_state   <= ST_STREAM;
                        busy      <= 1'b1;
                        start     <= 1'b1;
                        data_out  <= w_rd_data;
                        r_exp_max <= w_rd_data;
                        r_rd_ptr  <= r_rd_ptr + 1'b1;
                        r_sent    <= c_CW'(1);
                    end else if (w_wr_ok) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        count    <= count + 1'b1;
                    end
                end

                ST_STREAM: begin
                    if (r_sent == count) begin
                        // Last sample was presented this cycle.
                        r_state <= ST_DRAIN;
                        start   <= 1'b0;
                        r_wait  <= '0;
                    end else begin
                        data_out <= w_rd_data;
                        if (w_rd_data > r_exp_max) begin
                            r_exp_max <= w_rd_data;
                        end
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_sent   <= r_sent + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (done_in) begin
                        result       <= max_in;
                        mismatch     <= (max_in != r_exp_max);
                        timeout      <= 1'b0;
                        result_valid <= 1'b1;
                        r_state      <= ST_REPORT;
                    end else if (r_wait == c_TW'(TIMEOUT)) begin
                        result       <= '0;
                        mismatch     <= 1'b0;
                        timeout      <= 1'b1;
                        result_valid <= 1'b1;
                        r_state      <= ST_REPORT;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end

                ST_REPORT: begin
                    r_state  <= ST_IDLE;
                    busy     <= 1'b0;
                    count    <= '0;
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_sent   <= '0;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_max_seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_max_seq_driver
// Description : Self-checking bench for max_seq_driver. Table of run vectors
//               plus hand sequences for reset, empty go and mid-run reset.
//               A small datapath model answers done/max_in; streamed samples
//               are checked against a write-order scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max_seq_driver;

    localparam int c_DW = 8;
    localparam int c_DEPTH = 16;
    localparam int c_TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0;
    logic [c_DW-1:0]   wr_data = '0;
    logic              go = 1'b0;
    logic              busy;
    logic [4:0]        count;
    logic              start;
    logic [c_DW-1:0]   data_out;
    logic              done_in = 1'b0;
    logic [c_DW-1:0]   max_in = '0;
    logic [c_DW-1:0]   result;
    logic              result_valid;
    logic              mismatch;
    logic              timeout;
    logic              wr_err;

    max_seq_driver #(
        .DATA_W (c_DW),
        .DEPTH  (c_DEPTH),
        .TIMEOUT(c_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .go          (go),
        .busy        (busy),
        .count       (count),
        .start       (start),
        .data_out    (data_out),
        .done_in     (done_in),
        .max_in      (max_in),
        .result      (result),
        .result_valid(result_valid),
        .mismatch    (mismatch),
        .timeout     (timeout),
        .wr_err      (wr_err)
    );

    always #5 clk = ~clk;

    // mode: 0 = model returns true max, 1 = model returns model_max, 2 = no done
    typedef struct {
        int                 n;
        logic [15:0][7:0]   s;
        bit                 extra_write;
        bit                 go_wr;
        bit                 mid_reset;
        int                 mode;
        logic [7:0]         model_max;
        logic [7:0]         exp_result;
        bit                 exp_mis;
        bit                 exp_to;
        int                 exp_lat;
        bit                 exp_wr_err;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Load 4 samples, go, then pull reset during the second STREAM cycle.
    task automatic mid_stream_reset();
        for (int k = 0; k < 4; k++) load(8'(11 * (k + 1)));
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        chk("mid_start_before", 32'(start), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_start", 32'(start), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_wr_err", 32'(wr_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        sb_q.delete();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit got;
        bit prev_start;
        int starts;
        logic [7:0] e;
        string tag;
        tag = $sformatf("v%0d", idx);
        if (v.mid_reset) mid_stream_reset();
        for (int k = 0; k < v.n; k++) begin
            load(v.s[k]);
            sb_q.push_back(v.s[k]);
        end
        if (v.extra_write) begin
            load(8'hAA);
            chk({tag, "_full_count"}, 32'(count), 32'd16);
            chk({tag, "_full_wr_err"}, 32'(wr_err), 32'd1);
        end
        chk({tag, "_count"}, 32'(count), 32'(v.n));
        go = 1'b1;
        if (v.go_wr) begin
            wr_en = 1'b1;
            wr_data = 8'd99;
        end
        tick();
        go = 1'b0;
        wr_en = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        got = 1'b0;
        prev_start = 1'b0;
        starts = 0;
        for (int c = 1; c <= 40; c++) begin
            if (start) begin
                starts++;
                if (sb_q.size() == 0) begin
                    chk({tag, "_extra_start"}, 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk({tag, "_data_out"}, 32'(data_out), 32'(e));
                end
            end
            done_in = prev_start && !start && (v.mode != 2);
            max_in  = v.model_max;
            if (result_valid) begin
                chk({tag, "_latency"}, 32'(c), 32'(v.exp_lat));
                chk({tag, "_result"}, 32'(result), 32'(v.exp_result));
                chk({tag, "_mismatch"}, 32'(mismatch), 32'(v.exp_mis));
                chk({tag, "_timeout"}, 32'(timeout), 32'(v.exp_to));
                chk({tag, "_starts"}, 32'(starts), 32'(v.n));
                got = 1'b1;
                break;
            end
            prev_start = start;
            tick();
        end
        done_in = 1'b0;
        if (!got) chk({tag, "_result_valid_seen"}, 32'd0, 32'd1);
        tick();
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_rv_pulse"}, 32'(result_valid), 32'd0);
        chk({tag, "_count_after"}, 32'(count), 32'd0);
        chk({tag, "_wr_err"}, 32'(wr_err), 32'(v.exp_wr_err));
        sb_q.delete();
    endtask

    vec_t vecs[7];

    initial begin
        for (int i = 0; i < 7; i++) begin
            vecs[i].n = 0; vecs[i].s = '0; vecs[i].extra_write = 0;
            vecs[i].go_wr = 0; vecs[i].mid_reset = 0; vecs[i].mode = 0;
            vecs[i].model_max = 0; vecs[i].exp_result = 0; vecs[i].exp_mis = 0;
            vecs[i].exp_to = 0; vecs[i].exp_lat = 0; vecs[i].exp_wr_err = 0;
        end
        // 3,9,4 nominal run
        vecs[0].n = 3; vecs[0].s[0] = 8'd3; vecs[0].s[1] = 8'd9; vecs[0].s[2] = 8'd4;
        vecs[0].model_max = 8'd9; vecs[0].exp_result = 8'd9; vecs[0].exp_lat = 5;
        // go together with wr_en: write dropped, stream of 2
        vecs[1].n = 2; vecs[1].s[0] = 8'd10; vecs[1].s[1] = 8'd20; vecs[1].go_wr = 1;
        vecs[1].model_max = 8'd20; vecs[1].exp_result = 8'd20; vecs[1].exp_lat = 4;
        vecs[1].exp_wr_err = 1;
        // full buffer plus dropped 17th write, preceded by a mid-run reset
        vecs[2].n = 16; vecs[2].extra_write = 1; vecs[2].mid_reset = 1;
        for (int k = 0; k < 16; k++) begin
            vecs[2].s[k] = 8'((k * 37 + 11) % 256);
            if (vecs[2].s[k] > vecs[2].exp_result) vecs[2].exp_result = vecs[2].s[k];
        end
        vecs[2].model_max = vecs[2].exp_result; vecs[2].exp_lat = 18; vecs[2].exp_wr_err = 1;
        // datapath reports a wrong max
        vecs[3].n = 2; vecs[3].s[0] = 8'd5; vecs[3].s[1] = 8'd7; vecs[3].mode = 1;
        vecs[3].model_max = 8'd5; vecs[3].exp_result = 8'd5; vecs[3].exp_mis = 1;
        vecs[3].exp_lat = 4; vecs[3].exp_wr_err = 1;
        // no done: timeout at DRAIN+9
        vecs[4].n = 1; vecs[4].s[0] = 8'd1; vecs[4].mode = 2; vecs[4].model_max = 8'd77;
        vecs[4].exp_to = 1; vecs[4].exp_lat = 11; vecs[4].exp_wr_err = 1;
        // unsigned compare with values above 127
        vecs[5].n = 4; vecs[5].s[0] = 8'd200; vecs[5].s[1] = 8'd17;
        vecs[5].s[2] = 8'd255; vecs[5].s[3] = 8'd0;
        vecs[5].model_max = 8'd255; vecs[5].exp_result = 8'd255; vecs[5].exp_lat = 6;
        vecs[5].exp_wr_err = 1;
        // all-zero samples
        vecs[6].n = 2; vecs[6].model_max = 8'd0; vecs[6].exp_result = 8'd0;
        vecs[6].exp_lat = 4; vecs[6].exp_wr_err = 1;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_flags", {29'd0, mismatch, timeout, wr_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // go with empty buffer is ignored
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("empty_go_busy", 32'(busy), 32'd0);
            chk("empty_go_start", 32'(start), 32'd0);
            tick();
        end

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
